// File: rtl/mem_bus_arbiter_if.sv
// CPU-side request/response ports and the shared ROM/RAM bus of the memory arbiter.
interface mem_bus_arbiter_if;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Load/store data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  // Shared memory bus
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rom_rd;
  logic              ram_rd;
  logic              ram_wr;
  logic              busy;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, d_err,
           mem_addr, mem_wdata, rom_rd, ram_rd, ram_wr, busy
  );

  // CPU / memory-model view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, d_err,
           mem_addr, mem_wdata, rom_rd, ram_rd, ram_wr, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the 13-bit ROM/RAM bus between fetch and data ports,
// with fixed per-region wait states and a one-cycle ack pulse per access.
module mem_bus_arbiter #(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_WAIT - 1);
  localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              rom_rd_q, rom_rd_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic              busy_q, busy_d;

  logic              if_req_c;
  logic              d_req_c;
  logic              grant_c;
  logic              grant_d_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic              gnt_ram_c;

  // Eligible requests (a port is masked in its own ack cycle) and round-robin pick
  always_comb begin
    if_req_c   = bus.if_req & ~if_ack_q;
    d_req_c    = bus.d_req & ~d_ack_q;
    grant_c    = if_req_c | d_req_c;
    grant_d_c  = d_req_c & (~if_req_c | (last_grant_q == OWN_FETCH));
    gnt_addr_c = grant_d_c ? bus.d_addr : bus.if_addr;
    gnt_ram_c  = (gnt_addr_c[12:11] == 2'b11);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    rom_rd_d     = 1'b0;
    ram_rd_d     = 1'b0;
    ram_wr_d     = 1'b0;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_c) begin
          mem_addr_d   = gnt_addr_c;
          owner_d      = grant_d_c ? OWN_DATA : OWN_FETCH;
          last_grant_d = grant_d_c ? OWN_DATA : OWN_FETCH;
          if (grant_d_c) begin
            mem_wdata_d = bus.d_wdata;
          end
          if (grant_d_c && bus.d_we && !gnt_ram_c) begin
            // ROM is read-only: reject without touching the bus
            state_d = ERR;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = gnt_ram_c ? RAM_CNT : ROM_CNT;
            if (!gnt_ram_c) begin
              rom_rd_d = 1'b1;
            end else if (grant_d_c && bus.d_we) begin
              ram_wr_d = 1'b1;
            end else begin
              ram_rd_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          rom_rd_d = rom_rd_q;
          ram_rd_d = ram_rd_q;
          ram_wr_d = ram_wr_q;
        end else begin
          state_d = IDLE;
          if (owner_q == OWN_DATA) begin
            d_ack_d = 1'b1;
            if (!ram_wr_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy also spans the ack/turnaround cycle
    busy_d = (state_d != IDLE) | if_ack_d | d_ack_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_FETCH;
      last_grant_q <= OWN_FETCH;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      rom_rd_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      rom_rd_q     <= rom_rd_d;
      ram_rd_q     <= ram_rd_d;
      ram_wr_q     <= ram_wr_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.rom_rd    = rom_rd_q;
  assign bus.ram_rd    = ram_rd_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with ROM_WAIT=2, RAM_WAIT=1.
module tb_mem_bus_arbiter;

  typedef struct {
    int n_rom;
    int n_rrd;
    int n_rwr;
    int n_busy;
    int n_ack;
    int n_err;
    int ack_k;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks   = 0;
  int         failures = 0;
  int         inv_err  = 0;
  logic [7:0] ram [0:2047];
  logic       strobe_prev = 1'b0;
  logic [12:0] addr_prev  = '0;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.ROM_WAIT(2), .RAM_WAIT(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [12:0] a);
    return (a == 13'h0004) ? 8'h5A : (a[7:0] ^ 8'h81);
  endfunction

  // Memory model: ROM is a fixed function, RAM an array written on ram_wr
  always_comb begin
    if (bus.rom_rd)      bus.mem_rdata = rom_val(bus.mem_addr);
    else if (bus.ram_rd) bus.mem_rdata = ram[bus.mem_addr[10:0]];
    else                 bus.mem_rdata = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.mem_addr[10:0]] = bus.mem_wdata;
  end

  // Bus invariants, watched every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      if ((int'(bus.rom_rd) + int'(bus.ram_rd) + int'(bus.ram_wr)) > 1) inv_err++;
      if (bus.if_ack && bus.d_ack) inv_err++;
      if (strobe_prev && (bus.rom_rd | bus.ram_rd | bus.ram_wr) && (bus.mem_addr !== addr_prev)) inv_err++;
      strobe_prev = bus.rom_rd | bus.ram_rd | bus.ram_wr;
      addr_prev   = bus.mem_addr;
    end else begin
      strobe_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and measure strobe/ack/busy activity, cycle 1 = first cycle after grant edge
  task automatic do_xfer(input bit is_d, input bit we, input logic [12:0] addr,
                         input logic [7:0] wdata, output xfer_t r);
    int post;
    r = '{n_rom: 0, n_rrd: 0, n_rwr: 0, n_busy: 0, n_ack: 0, n_err: 0, ack_k: -1};
    post = 0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      r.n_rom  += int'(bus.rom_rd);
      r.n_rrd  += int'(bus.ram_rd);
      r.n_rwr  += int'(bus.ram_wr);
      r.n_busy += int'(bus.busy);
      r.n_err  += int'(bus.d_err);
      if (bus.if_ack || bus.d_ack) begin
        r.n_ack++;
        if (r.ack_k < 0) r.ack_k = k;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      if (r.ack_k >= 0) begin
        post++;
        if (post >= 3) break;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    rst_n = 1'b0;
    tick(); tick();
    ctl = {bus.if_ack, bus.d_ack, bus.d_err, bus.rom_rd, bus.ram_rd, bus.ram_wr, bus.busy};
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000000", ctl); end
    checks++; if (bus.mem_addr !== 13'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", bus.mem_addr); end
    checks++; if ({bus.if_rdata, bus.d_rdata, bus.mem_wdata} !== 24'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=000000", {bus.if_rdata, bus.d_rdata, bus.mem_wdata}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rom_fetch();
    xfer_t r;
    do_xfer(1'b0, 1'b0, 13'h0004, 8'h00, r);
    checks++; if (r.n_rom !== 2) begin failures++; $display("FAIL fetch_rom_rd_cycles got=%0d exp=2", r.n_rom); end
    checks++; if (r.ack_k !== 3) begin failures++; $display("FAIL fetch_ack_cycle got=%0d exp=3", r.ack_k); end
    checks++; if (r.n_ack !== 1) begin failures++; $display("FAIL fetch_ack_count got=%0d exp=1", r.n_ack); end
    checks++; if (r.n_busy !== 3) begin failures++; $display("FAIL fetch_busy_cycles got=%0d exp=3", r.n_busy); end
    checks++; if (bus.if_rdata !== 8'h5A) begin failures++; $display("FAIL fetch_rdata got=%h exp=5a", bus.if_rdata); end
  endtask

  task automatic test_ram_write_read();
    xfer_t r;
    do_xfer(1'b1, 1'b1, 13'h1800, 8'hC3, r);
    checks++; if (r.n_rwr !== 1 || r.n_rom !== 0 || r.n_rrd !== 0) begin failures++;
      $display("FAIL wr_strobes got=%0d/%0d/%0d exp=1/0/0", r.n_rwr, r.n_rom, r.n_rrd); end
    checks++; if (r.ack_k !== 2) begin failures++; $display("FAIL wr_ack_cycle got=%0d exp=2", r.ack_k); end
    checks++; if (r.n_err !== 0) begin failures++; $display("FAIL wr_err got=%0d exp=0", r.n_err); end
    do_xfer(1'b1, 1'b0, 13'h1800, 8'h00, r);
    checks++; if (r.n_rrd !== 1) begin failures++; $display("FAIL rd_ram_rd_cycles got=%0d exp=1", r.n_rrd); end
    checks++; if (r.ack_k !== 2) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=2", r.ack_k); end
    checks++; if (bus.d_rdata !== 8'hC3) begin failures++; $display("FAIL rd_rdata got=%h exp=c3", bus.d_rdata); end
    checks++; if (bus.if_rdata !== 8'h5A) begin failures++; $display("FAIL if_rdata_held got=%h exp=5a", bus.if_rdata); end
  endtask

  task automatic test_contention();
    int  ack_at [4] = '{-1, -1, -1, -1};
    bit  ack_d  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int  exp_at [4] = '{2, 5, 7, 10};
    bit  exp_d  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int  n;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    n = 0;
    bus.if_addr = 13'h0010; bus.d_addr = 13'h1FFF; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) begin
        checks++; if ({bus.ram_rd, bus.rom_rd} !== 2'b10) begin failures++;
          $display("FAIL tie_first_grant got=%b exp=10", {bus.ram_rd, bus.rom_rd}); end
      end
      if ((bus.if_ack || bus.d_ack) && n < 4) begin
        ack_at[n] = k; ack_d[n] = bus.d_ack; n++;
      end
      if (n == 4) break;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack_at[i] !== exp_at[i] || ack_d[i] !== exp_d[i]) begin failures++;
        $display("FAIL rr_ack%0d got=cyc%0d d=%0d exp=cyc%0d d=%0d", i, ack_at[i], ack_d[i], exp_at[i], exp_d[i]); end
    end
    checks++; if (bus.if_rdata !== 8'h91 || bus.d_rdata !== 8'h69) begin failures++;
      $display("FAIL rr_rdata got=%h/%h exp=91/69", bus.if_rdata, bus.d_rdata); end
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_idle_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_rom_write_err();
    xfer_t r;
    do_xfer(1'b1, 1'b1, 13'h17FF, 8'hAA, r);
    checks++; if (r.n_rom + r.n_rrd + r.n_rwr !== 0) begin failures++;
      $display("FAIL err_strobes got=%0d exp=0", r.n_rom + r.n_rrd + r.n_rwr); end
    checks++; if (r.ack_k !== 1) begin failures++; $display("FAIL err_ack_cycle got=%0d exp=1", r.ack_k); end
    checks++; if (r.n_err !== 1 || r.n_ack !== 1) begin failures++;
      $display("FAIL err_pulse got=err%0d ack%0d exp=err1 ack1", r.n_err, r.n_ack); end
    checks++; if (r.n_busy !== 1) begin failures++; $display("FAIL err_busy got=%0d exp=1", r.n_busy); end
    checks++; if (bus.d_rdata !== 8'h69) begin failures++; $display("FAIL err_rdata_held got=%h exp=69", bus.d_rdata); end
  endtask

  task automatic test_boundary();
    xfer_t r;
    do_xfer(1'b1, 1'b0, 13'h17FF, 8'h00, r);
    checks++; if (r.n_rom !== 2 || r.n_rrd !== 0 || r.ack_k !== 3) begin failures++;
      $display("FAIL bnd_17ff got=rom%0d ram%0d ack%0d exp=rom2 ram0 ack3", r.n_rom, r.n_rrd, r.ack_k); end
    checks++; if (bus.d_rdata !== 8'h7E) begin failures++; $display("FAIL bnd_17ff_data got=%h exp=7e", bus.d_rdata); end
    do_xfer(1'b1, 1'b0, 13'h1800, 8'h00, r);
    checks++; if (r.n_rrd !== 1 || r.n_rom !== 0 || r.ack_k !== 2) begin failures++;
      $display("FAIL bnd_1800 got=ram%0d rom%0d ack%0d exp=ram1 rom0 ack2", r.n_rrd, r.n_rom, r.ack_k); end
    checks++; if (bus.d_rdata !== 8'hC3) begin failures++; $display("FAIL bnd_1800_data got=%h exp=c3", bus.d_rdata); end
    do_xfer(1'b0, 1'b0, 13'h1FFF, 8'h00, r);
    checks++; if (r.n_rrd !== 1 || r.n_rom !== 0 || r.ack_k !== 2) begin failures++;
      $display("FAIL bnd_fetch_1fff got=ram%0d rom%0d ack%0d exp=ram1 rom0 ack2", r.n_rrd, r.n_rom, r.ack_k); end
    checks++; if (bus.if_rdata !== 8'h69) begin failures++; $display("FAIL bnd_fetch_data got=%h exp=69", bus.if_rdata); end
  endtask

  task automatic test_reset_mid_access();
    xfer_t r;
    int    n;
    logic [5:0] ctl;
    bus.if_addr = 13'h0004; bus.if_req = 1'b1;
    tick();
    checks++; if (bus.rom_rd !== 1'b1) begin failures++; $display("FAIL mid_rom_rd got=%b exp=1", bus.rom_rd); end
    #2 rst_n = 1'b0;
    #1;
    ctl = {bus.rom_rd, bus.ram_rd, bus.ram_wr, bus.busy, bus.if_ack, bus.d_ack};
    checks++; if (ctl !== 6'b0) begin failures++; $display("FAIL mid_async_clear got=%b exp=000000", ctl); end
    bus.if_req = 1'b0;
    n = 0;
    repeat (3) begin
      tick();
      if (bus.if_ack || bus.d_ack) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL mid_no_ack got=%0d exp=0", n); end
    checks++; if (bus.if_rdata !== 8'h00) begin failures++; $display("FAIL mid_rdata_cleared got=%h exp=00", bus.if_rdata); end
    rst_n = 1'b1;
    tick();
    do_xfer(1'b0, 1'b0, 13'h0008, 8'h00, r);
    checks++; if (r.ack_k !== 3 || r.n_rom !== 2) begin failures++;
      $display("FAIL mid_recover got=ack%0d rom%0d exp=ack3 rom2", r.ack_k, r.n_rom); end
    checks++; if (bus.if_rdata !== 8'h89) begin failures++; $display("FAIL mid_recover_data got=%h exp=89", bus.if_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'h96;
    rst_n       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    test_reset();
    test_rom_fetch();
    test_ram_write_read();
    test_contention();
    test_rom_write_err();
    test_boundary();
    test_reset_mid_access();
    checks++; if (inv_err !== 0) begin failures++; $display("FAIL invariants got=%0d exp=0", inv_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
